// File: rtl/regfile_mp_swc.sv
// Multi-read-port integer register file with write-pending scoreboard.
// Registered reads, optional write bypass, flat debug mirror.
module regfile_mp_swc #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 hclk,
  input  logic                 hrstn,
  input  logic                 reg_wen,
  input  logic [AW-1:0]        reg_waddr,
  input  logic [XLEN-1:0]      reg_wdata,
  input  logic [NRD-1:0]       reg_ren,
  input  logic [NRD*AW-1:0]    reg_raddr,
  output logic [NRD*XLEN-1:0]  reg_rdata,
  output logic [NRD-1:0]       reg_rbusy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NREG-1:0]      pending,
  output logic [NREG*XLEN-1:0] regfile_flat
);

  logic [XLEN-1:0]     rf [NREG];
  logic [NREG-1:0]     pend_q;
  logic [NRD*XLEN-1:0] rdata_d;
  logic [NRD*XLEN-1:0] rdata_q;
  logic [NRD-1:0]      rbusy_d;
  logic [NRD-1:0]      rbusy_q;
  logic                wlegal;
  logic                ilegal;

  // Qualify write and issue: in range, and not the hardwired zero register.
  always_comb begin
    wlegal = reg_wen
           && (32'(reg_waddr) < NREG)
           && !(ZERO_REG != 0 && reg_waddr == '0);
    ilegal = iss_valid
           && (32'(iss_rd) < NREG)
           && !(ZERO_REG != 0 && iss_rd == '0);
  end

  // Per-port read select; unmatched or disabled ports yield zero.
  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    for (int k = 0; k < NRD; k++) begin
      if (reg_ren[k]) begin
        for (int r = 0; r < NREG; r++) begin
          if (reg_raddr[k*AW +: AW] == AW'(r)
              && !(ZERO_REG != 0 && r == 0)) begin
            rdata_d[k*XLEN +: XLEN] = rf[r];
            rbusy_d[k] = pend_q[r];
            if (BYPASS != 0 && wlegal
                && reg_waddr == AW'(r)) begin
              rdata_d[k*XLEN +: XLEN] = reg_wdata;
              rbusy_d[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Register storage, cleared on reset.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wlegal && reg_waddr == AW'(r)) rf[r] <= reg_wdata;
      end
    end
  end

  // Scoreboard: a new issue outranks a retiring write to the same reg.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      pend_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (ilegal && iss_rd == AW'(r)) pend_q[r] <= 1'b1;
        else if (wlegal && reg_waddr == AW'(r)) pend_q[r] <= 1'b0;
      end
    end
  end

  // Read data and busy flags, one cycle after address.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regfile_flat[g*XLEN +: XLEN] = rf[g];
  end

  assign reg_rdata = rdata_q;
  assign reg_rbusy = rbusy_q;
  assign pending   = pend_q;

endmodule
